// File: rtl/crop_pkg.sv
// Shared geometry defaults and controller state encoding for the crop window scaler.
package crop_pkg;

  localparam int DEF_IMG_W      = 1280;
  localparam int DEF_IMG_H      = 720;
  localparam int DEF_WIN_W      = 300;
  localparam int DEF_WIN_H      = 150;
  localparam int DEF_NUM_SCALES = 3;
  localparam int DEF_STEP_W     = 40;
  localparam int DEF_STEP_H     = 20;
  localparam int DEF_COORD_W    = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/crop_axis_clamp.sv
// One image axis: places a window of the given size around the centre, kept inside [0, LIMIT-1].
module crop_axis_clamp #(
  parameter int COORD_W = 12,
  parameter int LIMIT   = 1280
) (
  input  logic [COORD_W-1:0] centre,
  input  logic [COORD_W:0]   size,
  output logic [COORD_W-1:0] start_pos,
  output logic [COORD_W-1:0] end_pos,
  output logic [COORD_W-1:0] rel_pos
);

  localparam int IW = COORD_W + 2;
  localparam logic signed [IW-1:0] LIM  = IW'(LIMIT);
  localparam logic signed [IW-1:0] ZERO = '0;
  localparam logic signed [IW-1:0] ONE  = IW'(1);

  logic signed [IW-1:0] c_s, sz_s, lo, hi, st;

  always_comb begin
    c_s  = signed'({2'b00, centre});
    sz_s = signed'({1'b0, size});
    lo   = c_s - (sz_s >>> 1);
    hi   = LIM - sz_s;
    // lower bound first, then upper: the upper bound wins near the far edge
    if (lo < ZERO)    st = ZERO;
    else if (lo > hi) st = hi;
    else              st = lo;
    start_pos = COORD_W'(st);
    end_pos   = COORD_W'(st + sz_s - ONE);
    rel_pos   = COORD_W'(c_s - st);
  end

endmodule

// File: rtl/crop_window_scaler.sv
// Emits NUM_SCALES nested crop windows around a requested centre, one per handshake.
// state | meaning: IDLE wait for start; CALC register window for scl_q; OUT present window until accepted
module crop_window_scaler
  import crop_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int WIN_W      = DEF_WIN_W,
  parameter int WIN_H      = DEF_WIN_H,
  parameter int NUM_SCALES = DEF_NUM_SCALES,
  parameter int STEP_W     = DEF_STEP_W,
  parameter int STEP_H     = DEF_STEP_H,
  parameter int COORD_W    = DEF_COORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               start_ready,
  input  logic [15:0]        mid_x,
  input  logic [15:0]        mid_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         scale_idx,
  output logic               last,
  output logic [COORD_W-1:0] x_start,
  output logic [COORD_W-1:0] x_end,
  output logic [COORD_W-1:0] y_start,
  output logic [COORD_W-1:0] y_end,
  output logic [COORD_W-1:0] rel_x,
  output logic [COORD_W-1:0] rel_y
);

  if ((WIN_W % 2) != 0 || (WIN_H % 2) != 0 || (STEP_W % 2) != 0 || (STEP_H % 2) != 0)
  begin : g_bad_even
    $error("crop_window_scaler: WIN_W, WIN_H, STEP_W and STEP_H must be even");
  end
  if ((NUM_SCALES % 2) == 0 || NUM_SCALES < 1 || NUM_SCALES > 15) begin : g_bad_scales
    $error("crop_window_scaler: NUM_SCALES must be odd and within 1..15");
  end

  localparam logic [3:0] LAST_IDX = 4'(NUM_SCALES - 1);

  function automatic logic [COORD_W:0] scale_size(input int base, input int step,
                                                   input int idx, input int lim);
    int v;
    v = base + (idx - (NUM_SCALES - 1) / 2) * step;
    if (v < 2)        v = 2;
    else if (v > lim) v = lim;
    return (COORD_W + 1)'(v);
  endfunction

  state_t             state_q, state_d;
  logic [3:0]         scl_q;
  logic               last_q;
  logic [COORD_W-1:0] cx_q, cy_q, cx_next, cy_next;
  logic [COORD_W:0]   size_w, size_h;
  logic [COORD_W-1:0] xs_c, xe_c, rx_c, ys_c, ye_c, ry_c;

  always_comb begin
    cx_next = (int'(mid_x) > IMG_W - 1) ? COORD_W'(IMG_W - 1) : COORD_W'(mid_x);
    cy_next = (int'(mid_y) > IMG_H - 1) ? COORD_W'(IMG_H - 1) : COORD_W'(mid_y);
    size_w  = scale_size(WIN_W, STEP_W, int'(scl_q), IMG_W);
    size_h  = scale_size(WIN_H, STEP_H, int'(scl_q), IMG_H);
  end

  crop_axis_clamp #(.COORD_W(COORD_W), .LIMIT(IMG_W)) u_clamp_x (
    .centre(cx_q), .size(size_w), .start_pos(xs_c), .end_pos(xe_c), .rel_pos(rx_c)
  );

  crop_axis_clamp #(.COORD_W(COORD_W), .LIMIT(IMG_H)) u_clamp_y (
    .centre(cy_q), .size(size_h), .start_pos(ys_c), .end_pos(ye_c), .rel_pos(ry_c)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CALC;
      ST_CALC: state_d = ST_OUT;
      ST_OUT:  if (out_ready) state_d = (scl_q == LAST_IDX) ? ST_IDLE : ST_CALC;
      default: state_d = ST_IDLE;
    endcase
  end

  assign start_ready = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_OUT);
  assign last        = last_q && (state_q == ST_OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      scl_q     <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      scale_idx <= '0;
      last_q    <= 1'b0;
      x_start   <= '0;
      x_end     <= '0;
      y_start   <= '0;
      y_end     <= '0;
      rel_x     <= '0;
      rel_y     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        cx_q  <= cx_next;
        cy_q  <= cy_next;
        scl_q <= '0;
      end
      // outputs only change here, so they are frozen for the whole OUT stall
      if (state_q == ST_CALC) begin
        x_start   <= xs_c;
        x_end     <= xe_c;
        y_start   <= ys_c;
        y_end     <= ye_c;
        rel_x     <= rx_c;
        rel_y     <= ry_c;
        scale_idx <= scl_q;
        last_q    <= (scl_q == LAST_IDX);
      end
      if (state_q == ST_OUT && out_ready && scl_q != LAST_IDX) scl_q <= scl_q + 4'd1;
    end
  end

endmodule
